// File: rtl/ds_stage.sv
// ds_stage: dispatch stage holding renamed uop bundles and steering each uop to its reservation station.
// Ports: clk/rst (sync, active-low), flush from the ROB, prv_* bundle handshake from rename,
// rs_{int,md,mem,br}_{valid,ready,uop} one write channel per station.
// Build option: DS_SKID_BUFFER_EN selects a 2-entry bundle FIFO with a registered-state prv_ready;
// without it a single entry is kept and prv_ready may follow the stations' readys combinationally.
package ds_pkg;
  typedef enum logic [1:0] {RS_INT, RS_MD, RS_MEM, RS_BR} rs_type_t;
  typedef struct packed {
    logic        valid;
    logic [7:0]  op;
    logic [15:0] imm;
  } uop_t;
endpackage

module ds_stage import ds_pkg::*; #(
  parameter int ID_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     prv_valid,
  output logic                     prv_ready,
  input  logic [ID_WIDTH-1:0]      prv_uops_valid,
  input  rs_type_t [ID_WIDTH-1:0]  prv_rs_type,
  input  uop_t [ID_WIDTH-1:0]      prv_uops,
  output logic                     rs_int_valid,
  input  logic                     rs_int_ready,
  output uop_t                     rs_int_uop,
  output logic                     rs_md_valid,
  input  logic                     rs_md_ready,
  output uop_t                     rs_md_uop,
  output logic                     rs_mem_valid,
  input  logic                     rs_mem_ready,
  output uop_t                     rs_mem_uop,
  output logic                     rs_br_valid,
  input  logic                     rs_br_ready,
  output uop_t                     rs_br_uop
);
`ifdef DS_SKID_BUFFER_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  // Entry 0 is always the head; younger entries shift down on pop.
  logic [DEPTH-1:0]                    vld_q, vld_d;
  logic [DEPTH-1:0][ID_WIDTH-1:0]      uv_q, uv_d;
  rs_type_t [DEPTH-1:0][ID_WIDTH-1:0]  typ_q, typ_d;
  uop_t [DEPTH-1:0][ID_WIDTH-1:0]      uop_q, uop_d;
  logic [ID_WIDTH-1:0]                 sent_q, sent_d;
  logic [ID_WIDTH-1:0]                 pend, fire;
  logic [3:0][ID_WIDTH-1:0]            gnt;
  logic [3:0]                          rs_v, rs_r;
  uop_t [3:0]                          rs_u;
  logic                                done, cap, put;

  assign rs_r = {rs_br_ready, rs_mem_ready, rs_md_ready, rs_int_ready};

  // Per station, the lowest-numbered unsent head slot wins; rst gates every offer.
  always_comb begin
    pend = '0;
    gnt  = '0;
    rs_v = '0;
    rs_u = '0;
    fire = '0;
    for (int i = 0; i < ID_WIDTH; i++) begin
      pend[i] = rst && vld_q[0] && uv_q[0][i] && !sent_q[i];
      if (pend[i] && !rs_v[typ_q[0][i]]) begin
        gnt[typ_q[0][i]][i] = 1'b1;
        rs_v[typ_q[0][i]]   = 1'b1;
        rs_u[typ_q[0][i]]   = uop_q[0][i];
      end
    end
    for (int x = 0; x < 4; x++) begin
      rs_u[x].valid = rs_v[x];
      for (int i = 0; i < ID_WIDTH; i++) fire[i] = fire[i] | (gnt[x][i] & rs_r[x]);
    end
  end

  // Invalid slots count as already sent, so an empty bundle completes immediately at head.
  assign done = vld_q[0] && &(sent_q | fire | ~uv_q[0]);

`ifdef DS_SKID_BUFFER_EN
  assign prv_ready = rst && !flush && !vld_q[DEPTH-1];
`else
  assign prv_ready = rst && !flush && (!vld_q[0] || done);
`endif

  assign cap = prv_valid && prv_ready;

  always_comb begin
    vld_d = vld_q;
    uv_d  = uv_q;
    typ_d = typ_q;
    uop_d = uop_q;
    put   = cap;
    if (done) begin
      for (int d = 0; d < DEPTH - 1; d++) begin
        vld_d[d] = vld_q[d+1];
        uv_d[d]  = uv_q[d+1];
        typ_d[d] = typ_q[d+1];
        uop_d[d] = uop_q[d+1];
      end
      vld_d[DEPTH-1] = 1'b0;
    end
    for (int d = 0; d < DEPTH; d++) begin
      if (put && !vld_d[d]) begin
        vld_d[d] = 1'b1;
        uv_d[d]  = prv_uops_valid;
        typ_d[d] = prv_rs_type;
        uop_d[d] = prv_uops;
        put      = 1'b0;
      end
    end
    sent_d = done ? '0 : (sent_q | fire);
  end

  // Reset and flush share one path so a partly sent bundle never resumes.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      vld_q  <= '0;
      sent_q <= '0;
    end else begin
      vld_q  <= vld_d;
      sent_q <= sent_d;
    end
    uv_q  <= uv_d;
    typ_q <= typ_d;
    uop_q <= uop_d;
  end

  assign rs_int_valid = rs_v[RS_INT];
  assign rs_int_uop   = rs_u[RS_INT];
  assign rs_md_valid  = rs_v[RS_MD];
  assign rs_md_uop    = rs_u[RS_MD];
  assign rs_mem_valid = rs_v[RS_MEM];
  assign rs_mem_uop   = rs_u[RS_MEM];
  assign rs_br_valid  = rs_v[RS_BR];
  assign rs_br_uop    = rs_u[RS_BR];
endmodule

// File: tb/tb_ds_stage.sv
// tb_ds_stage: randomized self-checking bench for ds_stage against a bundle-queue reference model.
module tb_ds_stage;
  import ds_pkg::*;
`ifdef DS_SKID_BUFFER_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic prv_valid = 1'b0;
  logic prv_ready;
  logic [1:0] prv_uops_valid = '0;
  rs_type_t [1:0] prv_rs_type = {RS_INT, RS_INT};
  uop_t [1:0] prv_uops = '0;
  logic [3:0] rdy = '1;
  logic [3:0] vo;
  uop_t [3:0] uo;

  typedef struct {
    logic [1:0]     uv;
    rs_type_t [1:0] typ;
    uop_t [1:0]     u;
    logic [1:0]     sent;
  } bun_t;
  bun_t q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ds_stage #(.ID_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .prv_valid(prv_valid), .prv_ready(prv_ready),
    .prv_uops_valid(prv_uops_valid), .prv_rs_type(prv_rs_type), .prv_uops(prv_uops),
    .rs_int_valid(vo[0]), .rs_int_ready(rdy[0]), .rs_int_uop(uo[0]),
    .rs_md_valid(vo[1]), .rs_md_ready(rdy[1]), .rs_md_uop(uo[1]),
    .rs_mem_valid(vo[2]), .rs_mem_ready(rdy[2]), .rs_mem_uop(uo[2]),
    .rs_br_valid(vo[3]), .rs_br_ready(rdy[3]), .rs_br_uop(uo[3])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    int rst_hold = 0;
    logic [3:0] ev;
    uop_t eu [4];
    logic [1:0] fired;
    logic complete, er;
    bun_t nb;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (rst_hold > 0) rst_hold--;
      if (rst_hold == 0 && cyc >= 3 && $urandom_range(0, 149) == 0) rst_hold = 2;
      rst = !(cyc < 3 || rst_hold > 0);
      flush = ($urandom_range(0, 29) == 0);
      prv_valid = ($urandom_range(0, 3) != 0);
      prv_uops_valid = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        prv_rs_type[i] = rs_type_t'($urandom_range(0, 3));
        prv_uops[i].valid = 1'($urandom);
        prv_uops[i].op = 8'($urandom);
        prv_uops[i].imm = 16'($urandom);
      end
      if ($urandom_range(0, 2) == 0) prv_rs_type[1] = prv_rs_type[0];
      for (int x = 0; x < 4; x++) begin
        case ((cyc / 400) % 3)
          0: rdy[x] = 1'b1;
          1: rdy[x] = ($urandom_range(0, 1) == 0);
          default: rdy[x] = ($urandom_range(0, 3) == 0);
        endcase
      end
      #1;
      ev = '0;
      fired = '0;
      complete = 1'b0;
      for (int x = 0; x < 4; x++) eu[x] = '0;
      if (rst && q.size() > 0) begin
        for (int i = 0; i < 2; i++) begin
          if (q[0].uv[i] && !q[0].sent[i] && !ev[q[0].typ[i]]) begin
            ev[q[0].typ[i]] = 1'b1;
            eu[q[0].typ[i]] = q[0].u[i];
            eu[q[0].typ[i]].valid = 1'b1;
            fired[i] = rdy[q[0].typ[i]];
          end
        end
        complete = &(q[0].sent | fired | ~q[0].uv);
      end
      if (CAP == 2) er = rst && !flush && (q.size() < 2);
      else er = rst && !flush && (q.size() == 0 || complete);
      check("prv_ready", 32'(prv_ready), 32'(er));
      for (int x = 0; x < 4; x++) begin
        check($sformatf("rs%0d_valid", x), 32'(vo[x]), 32'(ev[x]));
        if (ev[x]) check($sformatf("rs%0d_uop", x), 32'(uo[x]), 32'(eu[x]));
        else check($sformatf("rs%0d_uop.valid", x), 32'(uo[x].valid), 32'd0);
      end
      if (!rst || flush) q.delete();
      else begin
        if (q.size() > 0) begin
          if (complete) void'(q.pop_front());
          else q[0].sent = q[0].sent | fired;
        end
        if (prv_valid && er) begin
          nb.uv = prv_uops_valid;
          nb.typ = prv_rs_type;
          nb.u = prv_uops;
          nb.sent = '0;
          q.push_back(nb);
        end
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
